sync_fifo_flags: RTL and testbench

- Parametrised successor to the team's basic synchronous FIFO, single clock domain.
- Uses every one of DEPTH entries: pointers carry an extra wrap bit.
- Adds occupancy count, programmable almost-full/almost-empty flags, and registered overflow/underflow error pulses.
- Sits between producer/consumer blocks in the verification DUT library; the standard buffering primitive for later testbenches.

---
 rtl/sync_fifo_flags.sv | 73 +++++++
 tb/tb_sync_fifo_flags.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with count, almost-full/empty flags and registered overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through; the default build has a 1-cycle registered read.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // The extra MSB on each pointer tells full apart from empty when the low bits match.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count        = wr_ptr - rd_ptr;
  assign almost_full  = (count >= AF_THR);
  assign almost_empty = (count <= AE_THR);

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= din;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      dout <= '0;
    else if (rd_acc) dout <= mem[rd_ptr[AW-1:0]];
  end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Randomized and directed bench for sync_fifo_flags against a queue-based reference model.
module tb_sync_fifo_flags;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          full, empty, almost_full, almost_empty;
  logic [3:0]    count;
  logic          overflow, underflow;

  sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_dout;
  logic          exp_ovf;
  logic          exp_unf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_dout();
`ifdef SYNC_FIFO_FWFT_EN
    return (q.size() > 0) ? q[0] : '0;
`else
    return exp_dout;
`endif
  endfunction

  task automatic check_all(input string phase);
    check_eq({phase, ":count"}, 32'(count), 32'(q.size()));
    check_eq({phase, ":empty"}, 32'(empty), 32'(q.size() == 0));
    check_eq({phase, ":full"}, 32'(full), 32'(q.size() == DEPTH));
    check_eq({phase, ":almost_full"}, 32'(almost_full), 32'(q.size() >= AF));
    check_eq({phase, ":almost_empty"}, 32'(almost_empty), 32'(q.size() <= AE));
    check_eq({phase, ":dout"}, 32'(dout), 32'(model_dout()));
    check_eq({phase, ":overflow"}, 32'(overflow), 32'(exp_ovf));
    check_eq({phase, ":underflow"}, 32'(underflow), 32'(exp_unf));
  endtask

  // One clock: drive inputs, advance the model on the edge, check just after it.
  task automatic cycle(input string phase, input logic w, input logic [DW-1:0] d, input logic r);
    bit was_full, was_empty;
    wr_en = w;
    din   = d;
    rd_en = r;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    exp_ovf   = w && was_full;
    exp_unf   = r && was_empty;
    if (r && !was_empty) exp_dout = q.pop_front();
    if (w && !was_full)  q.push_back(d);
    #1;
    check_all(phase);
  endtask

  task automatic model_reset();
    q.delete();
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
  endtask

  initial begin
    int pw, pr;
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // Asynchronous reset mid-cycle with three entries stored.
    for (int i = 0; i < 3; i++) cycle("prefill", 1'b1, DW'(8'hC0 + i), 1'b0);
    wr_en = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("async_rst:count", 32'(count), 32'd0);
    check_eq("async_rst:empty", 32'(empty), 32'd1);
    check_eq("async_rst:dout", 32'(dout), 32'd0);
    check_all("async_rst");
    #2 rst_n = 1'b1;

    // Fill to full.
    for (int i = 0; i < DEPTH; i++) begin
      cycle("fill", 1'b1, DW'(8'h10 + i), 1'b0);
      check_eq("fill:ae_boundary", 32'(almost_empty), 32'(i + 1 <= 2));
      check_eq("fill:af_boundary", 32'(almost_full), 32'(i + 1 >= 6));
    end
    check_eq("fill:full", 32'(full), 32'd1);
    check_eq("fill:count8", 32'(count), 32'd8);

    // Overflow: write rejected while full.
    cycle("overflow", 1'b1, 8'hAA, 1'b0);
    check_eq("overflow:pulse", 32'(overflow), 32'd1);
    cycle("overflow_idle", 1'b0, 8'h00, 1'b0);
    check_eq("overflow:one_cycle", 32'(overflow), 32'd0);

    // Drain in order, then underflow while empty.
    for (int i = 0; i < DEPTH; i++) begin
      cycle("drain", 1'b0, 8'h00, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
      check_eq("drain:order", 32'(dout), 32'(8'h10 + i));
`endif
    end
    cycle("underflow", 1'b0, 8'h00, 1'b1);
    check_eq("underflow:pulse", 32'(underflow), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
    check_eq("underflow:dout_hold", 32'(dout), 32'h17);
`endif
    cycle("underflow_idle", 1'b0, 8'h00, 1'b0);
    check_eq("underflow:one_cycle", 32'(underflow), 32'd0);

`ifdef SYNC_FIFO_FWFT_EN
    cycle("fwft_write", 1'b1, 8'h55, 1'b0);
    check_eq("fwft:head", 32'(dout), 32'h55);
    cycle("fwft_pop", 1'b0, 8'h00, 1'b1);
    check_eq("fwft:empty", 32'(empty), 32'd1);
    check_eq("fwft:dout0", 32'(dout), 32'd0);
`endif

    // Simultaneous read/write at count 4; pointers wrap more than twice.
    for (int i = 0; i < 4; i++) cycle("sim_fill", 1'b1, DW'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle("simul", 1'b1, DW'($urandom), 1'b1);
      check_eq("simul:count4", 32'(count), 32'd4);
    end
    for (int i = 0; i < 4; i++) cycle("sim_drain", 1'b0, 8'h00, 1'b1);

    // Random traffic, biased in turn toward full, empty and balanced.
    for (int ph = 0; ph < 3; ph++) begin
      pw = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
      pr = 100 - pw;
      for (int i = 0; i < 150; i++)
        cycle("random", 1'($urandom_range(0, 99) < pw), DW'($urandom), 1'($urandom_range(0, 99) < pr));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
